// File: rtl/issue_ctrl_pkg.sv
// Shared types and sizing for the issue/completion controller.
package issue_ctrl_pkg;

    localparam int RS_SZ       = 5;
    localparam int RS_IDX_W    = $clog2(RS_SZ);
    localparam int PREG_W      = 6;
    localparam int MUL_LAT_DEF = 4;

    // Functional-unit class carried with every issued instruction.
    typedef enum logic [1:0] {
        FU_ALU   = 2'd0,
        FU_MUL   = 2'd1,
        FU_LOAD  = 2'd2,
        FU_STORE = 2'd3
    } fu_class_t;

    // One in-flight instruction as seen by the completion logic.
    typedef struct packed {
        logic                valid;
        logic [RS_IDX_W-1:0] rs_idx;
        logic [PREG_W-1:0]   tag;
        logic                dest_valid;
    } is_track_entry_t;

    // LOAD and STORE share the single memory tracking slot.
    function automatic logic is_mem_class(input fu_class_t fu);
        return (fu == FU_LOAD) || (fu == FU_STORE);
    endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Issue, memory-done and completion signals between the reservation station
// side (master) and the issue controller (slave).
//
// Issue handshake: an instruction transfers in a cycle where is_valid=1 and
// is_stall=0. is_stall is combinational, depends on is_valid, and is only
// ever asserted while is_valid=1; the RS must hold the instruction until it
// transfers. The *_start strobes mark the transfer cycle for each unit.
interface issue_ctrl_if;
    import issue_ctrl_pkg::*;

    logic                is_valid;
    logic [RS_IDX_W-1:0] is_rs_idx;
    logic [1:0]          is_fu;
    logic [PREG_W-1:0]   is_dest_tag;
    logic                is_dest_valid;
    logic                is_stall;
    logic                alu_start;
    logic                mul_start;
    logic                mem_start;
    logic                mem_done;
    logic                cdb_en;
    logic [PREG_W-1:0]   cdb_tag;
    logic                remove_en;
    logic [RS_IDX_W-1:0] remove_idx;

    modport master (
        output is_valid, is_rs_idx, is_fu, is_dest_tag, is_dest_valid, mem_done,
        input  is_stall, alu_start, mul_start, mem_start,
               cdb_en, cdb_tag, remove_en, remove_idx
    );

    modport slave (
        input  is_valid, is_rs_idx, is_fu, is_dest_tag, is_dest_valid, mem_done,
        output is_stall, alu_start, mul_start, mem_start,
               cdb_en, cdb_tag, remove_en, remove_idx
    );

endinterface

// File: rtl/issue_ctrl_mul_track_pipe.sv
// Shadow of the pipelined multiplier: one tracking entry per stage, shifting
// one stage per cycle unless frozen because the last stage cannot retire.
module mul_track_pipe
    import issue_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  is_track_entry_t in_entry,
    input  logic            freeze,
    output logic            out_valid,
    output is_track_entry_t out_entry
);

    is_track_entry_t stage [MUL_LAT];

    // Shift the stage entries; a frozen pipe holds every stage and takes no insert.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                stage[i] <= '0;
            end
        end else if (!freeze) begin
            stage[0] <= in_valid ? in_entry : '0;
            for (int i = 1; i < MUL_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_entry = stage[MUL_LAT-1];
    assign out_valid = stage[MUL_LAT-1].valid;

endmodule

// File: rtl/issue_ctrl.sv
// Issue/completion controller: accepts one instruction per cycle into the
// ALU slot, MUL tracking pipe or MEM slot, grants one completion per cycle
// (MUL > MEM > ALU) and registers the CDB broadcast and RS remove strobe.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         interrupt,
    issue_ctrl_if.slave  bus
);

    logic            flush;
    fu_class_t       fu;
    is_track_entry_t issue_entry;
    is_track_entry_t alu_slot;
    is_track_entry_t mem_slot;
    is_track_entry_t mul_out;
    is_track_entry_t winner;
    logic            mem_done_q;
    logic            mul_out_valid;
    logic            grant_mul;
    logic            grant_mem;
    logic            grant_alu;
    logic            mul_freeze;
    logic            blocked;
    logic            stall;
    logic            accept;
    logic            accept_alu;
    logic            accept_mul;
    logic            accept_mem;
    logic            cdb_en_q;
    logic [PREG_W-1:0]   cdb_tag_q;
    logic            remove_en_q;
    logic [RS_IDX_W-1:0] remove_idx_q;

    // An interrupt discards everything in flight exactly like reset.
    assign flush = reset | interrupt;
    assign fu    = fu_class_t'(bus.is_fu);

    assign issue_entry = '{valid:      1'b1,
                           rs_idx:     bus.is_rs_idx,
                           tag:        bus.is_dest_tag,
                           dest_valid: bus.is_dest_valid};

    // Fixed-priority completion arbiter; winner is all-zero when nothing is granted.
    always_comb begin
        grant_mul = mul_out_valid;
        grant_mem = !grant_mul && mem_slot.valid && mem_done_q;
        grant_alu = !grant_mul && !grant_mem && alu_slot.valid;
        winner    = '0;
        if (grant_mul) begin
            winner = mul_out;
        end else if (grant_mem) begin
            winner = mem_slot;
        end else if (grant_alu) begin
            winner = alu_slot;
        end
    end

    // A unit accepts a new instruction if its slot is free or retires this cycle.
    always_comb begin
        mul_freeze = mul_out_valid && !grant_mul;
        blocked    = 1'b0;
        case (fu)
            FU_ALU:            blocked = alu_slot.valid && !grant_alu;
            FU_MUL:            blocked = mul_freeze;
            FU_LOAD, FU_STORE: blocked = mem_slot.valid && !grant_mem;
            default:           blocked = 1'b0;
        endcase
        stall      = bus.is_valid && blocked;
        accept     = bus.is_valid && !blocked && !flush;
        accept_alu = accept && (fu == FU_ALU);
        accept_mul = accept && (fu == FU_MUL);
        accept_mem = accept && is_mem_class(fu);
    end

    assign bus.is_stall  = stall;
    assign bus.alu_start = accept_alu;
    assign bus.mul_start = accept_mul;
    assign bus.mem_start = accept_mem;

    mul_track_pipe #(
        .MUL_LAT (MUL_LAT)
    ) u_mul_pipe (
        .clock     (clock),
        .reset     (flush),
        .in_valid  (accept_mul),
        .in_entry  (issue_entry),
        .freeze    (mul_freeze),
        .out_valid (mul_out_valid),
        .out_entry (mul_out)
    );

    // ALU slot: one-cycle residency, reloadable in its own grant cycle.
    always_ff @(posedge clock) begin
        if (flush) begin
            alu_slot <= '0;
        end else if (accept_alu) begin
            alu_slot <= issue_entry;
        end else if (grant_alu) begin
            alu_slot <= '0;
        end
    end

    // MEM slot: waits for mem_done, then holds done until it wins arbitration.
    always_ff @(posedge clock) begin
        if (flush) begin
            mem_slot   <= '0;
            mem_done_q <= 1'b0;
        end else if (accept_mem) begin
            mem_slot   <= issue_entry;
            mem_done_q <= 1'b0;
        end else if (grant_mem) begin
            mem_slot   <= '0;
            mem_done_q <= 1'b0;
        end else if (mem_slot.valid && bus.mem_done) begin
            mem_done_q <= 1'b1;
        end
    end

    // Register the granted entry as the CDB broadcast and RS remove strobe.
    always_ff @(posedge clock) begin
        if (flush) begin
            cdb_en_q     <= 1'b0;
            cdb_tag_q    <= '0;
            remove_en_q  <= 1'b0;
            remove_idx_q <= '0;
        end else begin
            cdb_en_q     <= winner.valid && winner.dest_valid;
            cdb_tag_q    <= winner.tag;
            remove_en_q  <= winner.valid;
            remove_idx_q <= winner.rs_idx;
        end
    end

    assign bus.cdb_en     = cdb_en_q;
    assign bus.cdb_tag    = cdb_tag_q;
    assign bus.remove_en  = remove_en_q;
    assign bus.remove_idx = remove_idx_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios plus random traffic, all checked
// against a cycle-level model built from ready times and occupancy flags.
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    localparam int LAT = MUL_LAT_DEF;

    logic clock = 1'b0;
    logic reset;
    logic interrupt;

    issue_ctrl_if bus();

    issue_ctrl #(.MUL_LAT(LAT)) dut (
        .clock     (clock),
        .reset     (reset),
        .interrupt (interrupt),
        .bus       (bus)
    );

    // clock / reset
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model state
    typedef struct {
        int idx;
        int tag;
        bit dv;
    } op_t;

    bit   m_alu_v;
    op_t  m_alu;
    op_t  mul_q[$];
    int   mul_rdy[$];
    bit   m_mem_v;
    bit   m_mem_done;
    op_t  m_mem;
    int   cyc;

    bit   armed;
    bit   e_rm_en;
    bit   e_cdb_en;
    bit   e_zero;
    int   e_rm_idx;
    logic [PREG_W-1:0] exp_q[$];

    bit   i_v;
    int   i_fu;
    int   i_idx;
    int   i_tag;
    bit   i_dv;
    bit   i_md;
    bit   last_stall;
    bit   last_alu_start;
    int   seen_cdb;
    int   seen_rm;

    // driver tasks
    task automatic set_in(input bit v, input int fu, input int idx, input int tag,
                          input bit dv, input bit md);
        i_v = v; i_fu = fu; i_idx = idx; i_tag = tag; i_dv = dv; i_md = md;
        bus.is_valid      = v;
        bus.is_fu         = fu[1:0];
        bus.is_rs_idx     = idx[RS_IDX_W-1:0];
        bus.is_dest_tag   = tag[PREG_W-1:0];
        bus.is_dest_valid = dv;
        bus.mem_done      = md;
    endtask

    task automatic model_clear();
        m_alu_v    = 1'b0;
        m_mem_v    = 1'b0;
        m_mem_done = 1'b0;
        mul_q.delete();
        mul_rdy.delete();
        exp_q.delete();
    endtask

    // One clock cycle: check last cycle's registered results, check the
    // combinational response to the current inputs, then advance the model.
    task automatic tick();
        bit  mul_c, blocked, es, flush, acc;
        int  win;
        op_t w;
        logic [PREG_W-1:0] t;

        if (armed) begin
            check("remove_en", bus.remove_en, e_rm_en);
            check("cdb_en", bus.cdb_en, e_cdb_en);
            if (e_rm_en) check("remove_idx", bus.remove_idx, e_rm_idx);
            if (e_cdb_en && exp_q.size() > 0) begin
                t = exp_q.pop_front();
                check("cdb_tag", bus.cdb_tag, t);
            end
            if (e_zero) begin
                check("cdb_tag_rst", bus.cdb_tag, 0);
                check("remove_idx_rst", bus.remove_idx, 0);
            end
        end
        seen_cdb += int'(bus.cdb_en === 1'b1);
        seen_rm  += int'(bus.remove_en === 1'b1);

        #1;
        mul_c = (mul_q.size() > 0) && (mul_rdy[0] <= cyc);
        if (mul_c)                      win = 1;
        else if (m_mem_v && m_mem_done) win = 2;
        else if (m_alu_v)               win = 3;
        else                            win = 0;
        case (i_fu)
            0:       blocked = m_alu_v && (win != 3);
            1:       blocked = mul_c && (win != 1);
            default: blocked = m_mem_v && (win != 2);
        endcase
        es    = i_v && blocked;
        flush = (reset === 1'b1) || (interrupt === 1'b1);
        acc   = i_v && !es && !flush;
        if (armed) begin
            check("is_stall", bus.is_stall, es);
            check("alu_start", bus.alu_start, acc && (i_fu == 0));
            check("mul_start", bus.mul_start, acc && (i_fu == 1));
            check("mem_start", bus.mem_start, acc && (i_fu >= 2));
        end
        last_stall     = bus.is_stall;
        last_alu_start = bus.alu_start;

        e_rm_en  = 1'b0;
        e_cdb_en = 1'b0;
        e_zero   = 1'b0;
        if (flush) begin
            model_clear();
            e_zero   = 1'b1;
            e_rm_idx = 0;
        end else begin
            w = '{idx: 0, tag: 0, dv: 1'b0};
            if (win == 1) begin
                w = mul_q.pop_front();
                void'(mul_rdy.pop_front());
            end
            if (win == 2) begin
                w = m_mem;
                m_mem_v = 1'b0;
                m_mem_done = 1'b0;
            end else if (m_mem_v && i_md) begin
                m_mem_done = 1'b1;
            end
            if (win == 3) begin
                w = m_alu;
                m_alu_v = 1'b0;
            end
            if (win != 0) begin
                e_rm_en  = 1'b1;
                e_rm_idx = w.idx;
                if (w.dv) begin
                    e_cdb_en = 1'b1;
                    exp_q.push_back(w.tag[PREG_W-1:0]);
                end
            end
            if (acc) begin
                w = '{idx: i_idx, tag: i_tag, dv: i_dv};
                case (i_fu)
                    0: begin m_alu = w; m_alu_v = 1'b1; end
                    1: begin mul_q.push_back(w); mul_rdy.push_back(cyc + LAT); end
                    default: begin m_mem = w; m_mem_v = 1'b1; m_mem_done = 1'b0; end
                endcase
            end
        end
        cyc++;
        armed = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n, input bit md);
        for (int k = 0; k < n; k++) begin
            set_in(1'b0, 0, 0, 0, 1'b0, md);
            tick();
        end
    endtask

    initial begin
        int rv, rfu, rdv;
        armed = 1'b0;
        cyc = 0;
        e_rm_en = 1'b0; e_cdb_en = 1'b0; e_zero = 1'b0; e_rm_idx = 0;
        seen_cdb = 0; seen_rm = 0;
        model_clear();
        reset = 1'b1;
        interrupt = 1'b0;
        set_in(1'b0, 0, 0, 0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        tick();
        tick();
        reset = 1'b0;

        // 1: single ALU issue, idx 3 tag 12
        set_in(1'b1, 0, 3, 12, 1'b1, 1'b0);
        tick();
        check("t1_stall", last_stall, 0);
        idle(1, 1'b0);
        check("t1_cdb_en", bus.cdb_en, 1);
        check("t1_cdb_tag", bus.cdb_tag, 12);
        check("t1_remove_idx", bus.remove_idx, 3);
        idle(2, 1'b0);

        // 2: back-to-back ALU issues, tags 1..4
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 0, i, i, 1'b1, 1'b0);
            tick();
            check("t2_stall", last_stall, 0);
        end
        idle(3, 1'b0);

        // 3: MUL and ALU become ready together
        set_in(1'b1, 1, 1, 7, 1'b1, 1'b0);
        tick();
        idle(LAT - 2, 1'b0);
        set_in(1'b1, 0, 2, 9, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 0, 3, 10, 1'b1, 1'b0);
        tick();
        check("t3_conflict_stall", last_stall, 1);
        check("t3_mul_first", bus.cdb_tag, 7);
        tick();
        check("t3_retry_stall", last_stall, 0);
        check("t3_alu_second", bus.cdb_tag, 9);
        idle(3, 1'b0);

        // 4: LOAD occupancy and mem_done latency
        set_in(1'b1, 2, 0, 5, 1'b1, 1'b0);
        tick();
        for (int c = 1; c <= 7; c++) begin
            set_in(1'b1, 2, 1, 6, 1'b1, c == 6);
            tick();
            check("t4_stall", last_stall, c < 7);
        end
        check("t4_cdb_en", bus.cdb_en, 1);
        check("t4_cdb_tag", bus.cdb_tag, 5);
        idle(4, 1'b1);

        // 5: STORE frees its RS entry without a broadcast
        set_in(1'b1, 3, 2, 0, 1'b0, 1'b0);
        tick();
        idle(1, 1'b1);
        idle(1, 1'b0);
        check("t5_remove_en", bus.remove_en, 1);
        check("t5_remove_idx", bus.remove_idx, 2);
        check("t5_cdb_en", bus.cdb_en, 0);
        idle(2, 1'b0);

        // 6: interrupt discards an in-flight MUL and a same-cycle issue
        set_in(1'b1, 1, 1, 20, 1'b1, 1'b0);
        tick();
        idle(1, 1'b0);
        interrupt = 1'b1;
        set_in(1'b1, 0, 4, 21, 1'b1, 1'b0);
        tick();
        check("t6_alu_start", last_alu_start, 0);
        interrupt = 1'b0;
        seen_cdb = 0;
        seen_rm  = 0;
        idle(LAT + 4, 1'b0);
        check("t6_no_cdb", seen_cdb, 0);
        check("t6_no_remove", seen_rm, 0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 79) == 0);
            interrupt = ($urandom_range(0, 59) == 0);
            rv  = ($urandom_range(0, 9) < 7);
            rfu = $urandom_range(0, 3);
            rdv = (rfu == 3) ? 0 : int'($urandom_range(0, 7) != 0);
            set_in(rv[0], rfu, $urandom_range(0, RS_SZ - 1), $urandom_range(0, 63),
                   rdv[0], $urandom_range(0, 2) == 0);
            tick();
        end
        reset = 1'b0;
        interrupt = 1'b0;
        idle(LAT + 3, 1'b1);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
